// File: rtl/conv_pkg.sv
// Shared types and sizing for the conv-2 operand path: word type, loader
// state encoding and the per-phase beat counts.
package conv_pkg;

   localparam int BITWIDTH     = 16;
   localparam int FMAP2_IN_DIM = 14;
   localparam int KSIZE        = 5;
   localparam int NCH          = 2;

   localparam int K_BEATS = NCH * NCH * KSIZE * KSIZE;
   localparam int F_BEATS = NCH * FMAP2_IN_DIM * FMAP2_IN_DIM;

   typedef logic signed [BITWIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_K = 2'd1,
      LOAD_F = 2'd2,
      READY  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/conv2_operand_loader_if.sv
// Operand stream into the conv-2 loader: one signed word per valid/ready beat.
interface conv2_operand_loader_if #(
   parameter int BITWIDTH = conv_pkg::BITWIDTH
);

   logic signed [BITWIDTH-1:0] in_data;
   logic                       in_valid;
   logic                       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/nested_index_counter.sv
// Up to four nested wrapping index counters (idx0 fastest) with clear,
// increment enable and a flag marking the final index combination.
module nested_index_counter #(
   parameter  int DIM0 = 1,
   parameter  int DIM1 = 1,
   parameter  int DIM2 = 1,
   parameter  int DIM3 = 1,
   localparam int W0   = (DIM0 > 1) ? $clog2(DIM0) : 1,
   localparam int W1   = (DIM1 > 1) ? $clog2(DIM1) : 1,
   localparam int W2   = (DIM2 > 1) ? $clog2(DIM2) : 1,
   localparam int W3   = (DIM3 > 1) ? $clog2(DIM3) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [W0-1:0] idx0,
   output logic [W1-1:0] idx1,
   output logic [W2-1:0] idx2,
   output logic [W3-1:0] idx3,
   output logic          last
);

   logic wrap0, wrap1, wrap2, wrap3;

   always_comb begin
      wrap0 = (idx0 == W0'(DIM0 - 1));
      wrap1 = (idx1 == W1'(DIM1 - 1));
      wrap2 = (idx2 == W2'(DIM2 - 1));
      wrap3 = (idx3 == W3'(DIM3 - 1));
      last  = wrap0 && wrap1 && wrap2 && wrap3;
   end

   // An outer level only advances on the beat where every inner level wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx0 <= '0;
         idx1 <= '0;
         idx2 <= '0;
         idx3 <= '0;
      end else if (clr) begin
         idx0 <= '0;
         idx1 <= '0;
         idx2 <= '0;
         idx3 <= '0;
      end else if (inc) begin
         idx0 <= wrap0 ? '0 : idx0 + W0'(1);
         if (wrap0) begin
            idx1 <= wrap1 ? '0 : idx1 + W1'(1);
            if (wrap1) begin
               idx2 <= wrap2 ? '0 : idx2 + W2'(1);
               if (wrap2) begin
                  idx3 <= wrap3 ? '0 : idx3 + W3'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/conv2_operand_loader.sv
// Streams conv-2 weights and the layer-2 input map into registers and holds
// them, flagged valid, until the downstream array acknowledges consumption.
module conv2_operand_loader #(
   parameter int BITWIDTH = conv_pkg::BITWIDTH,
   parameter int FMAP_DIM = conv_pkg::FMAP2_IN_DIM,
   parameter int KSIZE    = conv_pkg::KSIZE,
   parameter int NCH      = conv_pkg::NCH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       reuse_kernel,
   conv2_operand_loader_if.slave      bus,
   output logic signed [BITWIDTH-1:0] kernel [NCH][NCH][KSIZE][KSIZE],
   output logic signed [BITWIDTH-1:0] featuremap1 [NCH][FMAP_DIM][FMAP_DIM],
   output logic                       operands_valid,
   input  logic                       consume,
   output logic                       busy
);

   import conv_pkg::*;

   localparam int CW = (NCH > 1)      ? $clog2(NCH)      : 1;
   localparam int KW = (KSIZE > 1)    ? $clog2(KSIZE)    : 1;
   localparam int FW = (FMAP_DIM > 1) ? $clog2(FMAP_DIM) : 1;

   loader_state_t state_q, state_d;

   logic          clr;
   logic          k_we, f_we;
   logic          k_last, f_last;
   logic [KW-1:0] k_col, k_row;
   logic [CW-1:0] k_ch, k_ker;
   logic [FW-1:0] f_col, f_row;
   logic [CW-1:0] f_ch;
   logic          f_unused_idx3;

   assign clr  = (state_q == IDLE) && start;
   assign k_we = (state_q == LOAD_K) && bus.in_valid;
   assign f_we = (state_q == LOAD_F) && bus.in_valid;

   nested_index_counter #(
      .DIM0 (KSIZE),
      .DIM1 (KSIZE),
      .DIM2 (NCH),
      .DIM3 (NCH)
   ) u_kcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (k_we),
      .idx0  (k_col),
      .idx1  (k_row),
      .idx2  (k_ch),
      .idx3  (k_ker),
      .last  (k_last)
   );

   nested_index_counter #(
      .DIM0 (FMAP_DIM),
      .DIM1 (FMAP_DIM),
      .DIM2 (NCH),
      .DIM3 (1)
   ) u_fcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (f_we),
      .idx0  (f_col),
      .idx1  (f_row),
      .idx2  (f_ch),
      .idx3  (f_unused_idx3),
      .last  (f_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // in_ready is decoded from the registered state only, never from in_valid.
   always_comb begin
      state_d        = state_q;
      busy           = 1'b0;
      operands_valid = 1'b0;
      bus.in_ready   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = reuse_kernel ? LOAD_F : LOAD_K;
         end
         LOAD_K: begin
            busy         = 1'b1;
            bus.in_ready = 1'b1;
            if (k_we && k_last) state_d = LOAD_F;
         end
         LOAD_F: begin
            busy         = 1'b1;
            bus.in_ready = 1'b1;
            if (f_we && f_last) state_d = READY;
         end
         READY: begin
            operands_valid = 1'b1;
            if (consume) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Storage is cleared by reset so an aborted load never leaves stale operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++)
            for (int c = 0; c < NCH; c++)
               for (int r = 0; r < KSIZE; r++)
                  for (int q = 0; q < KSIZE; q++)
                     kernel[k][c][r][q] <= '0;
         for (int c = 0; c < NCH; c++)
            for (int r = 0; r < FMAP_DIM; r++)
               for (int q = 0; q < FMAP_DIM; q++)
                  featuremap1[c][r][q] <= '0;
      end else begin
         if (k_we) kernel[k_ker][k_ch][k_row][k_col] <= bus.in_data;
         if (f_we) featuremap1[f_ch][f_row][f_col] <= bus.in_data;
      end
   end

endmodule

// File: tb/tb_conv2_operand_loader.sv
// Directed bench for conv2_operand_loader: full, stalled and reuse loads,
// ignored control pulses and an asynchronous reset in the middle of a load.
module tb_conv2_operand_loader;

   import conv_pkg::*;

   localparam int FD = FMAP2_IN_DIM;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  start;
   logic  reuse_kernel;
   logic  consume;
   logic  operands_valid;
   logic  busy;
   word_t kernel [NCH][NCH][KSIZE][KSIZE];
   word_t featuremap1 [NCH][FD][FD];

   int n_tests = 0;
   int n_fail  = 0;

   conv2_operand_loader_if #(.BITWIDTH(BITWIDTH)) bus ();

   conv2_operand_loader #(
      .BITWIDTH (BITWIDTH),
      .FMAP_DIM (FD),
      .KSIZE    (KSIZE),
      .NCH      (NCH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .reuse_kernel   (reuse_kernel),
      .bus            (bus),
      .kernel         (kernel),
      .featuremap1    (featuremap1),
      .operands_valid (operands_valid),
      .consume        (consume),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat order: col fastest, then row, channel, kernel.
   function automatic int kern_errs(input bit zero);
      int errs = 0;
      int idx;
      for (int k = 0; k < NCH; k++)
         for (int c = 0; c < NCH; c++)
            for (int r = 0; r < KSIZE; r++)
               for (int q = 0; q < KSIZE; q++) begin
                  idx = ((k * NCH + c) * KSIZE + r) * KSIZE + q;
                  if (int'(kernel[k][c][r][q]) != (zero ? 0 : idx)) errs++;
               end
      return errs;
   endfunction

   // mode 0: word = 100 + pixel index, 1: word = -pixel index, 2: all zero.
   function automatic int fm_errs(input int mode);
      int errs = 0;
      int idx, exp;
      for (int c = 0; c < NCH; c++)
         for (int r = 0; r < FD; r++)
            for (int q = 0; q < FD; q++) begin
               idx = (c * FD + r) * FD + q;
               exp = (mode == 0) ? K_BEATS + idx : (mode == 1) ? -idx : 0;
               if (int'(featuremap1[c][r][q]) != exp) errs++;
            end
      return errs;
   endfunction

   // Pulses start, then feeds word n (or -n) on beat n until operands_valid.
   // ps/pc pulse start/consume at that cycle; abort_at returns after that beat.
   task automatic run_load(input bit reuse, input bit gaps, input bit neg,
                           input int ps, input int pc, input int abort_at,
                           output int cyc, output int n);
      int total   = reuse ? F_BEATS : K_BEATS + F_BEATS;
      int rdy_err = 0;
      bit beat;
      n   = 0;
      cyc = 0;
      chk("idle_in_ready", bus.in_ready, 0);
      reuse_kernel = reuse;
      start        = 1'b1;
      bus.in_data  = word_t'(0);
      bus.in_valid = 1'b1;
      while (!operands_valid && cyc < 4000) begin
         beat = bus.in_valid && bus.in_ready;
         tick();
         cyc++;
         if (beat) n++;
         start   = (cyc == ps);
         consume = (cyc == pc);
         if (n == abort_at) return;
         if (bus.in_ready !== (n < total)) rdy_err++;
         bus.in_data  = word_t'(neg ? -n : n);
         bus.in_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
      end
      start   = 1'b0;
      consume = 1'b0;
      chk("load_done", operands_valid, 1);
      chk("beat_count", n, total);
      chk("in_ready_trace", rdy_err, 0);
   endtask

   task automatic do_consume(input string tag);
      consume = 1'b1;
      tick();
      consume = 1'b0;
      chk({tag, "_valid_drop"}, operands_valid, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
   endtask

   initial begin
      int cyc, n;
      logic [BITWIDTH-1:0] raw;

      rst_n        = 1'b0;
      start        = 1'b0;
      reuse_kernel = 1'b0;
      consume      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #12;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_valid", operands_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_kernel", kern_errs(1'b1), 0);
      chk("rst_fmap", fm_errs(2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Full load, in_valid held high.
      run_load(1'b0, 1'b0, 1'b0, -1, -1, -1, cyc, n);
      chk("t1_latency", cyc, 493);
      chk("t1_busy", busy, 0);
      chk("t1_k1144", int'(kernel[1][1][4][4]), 99);
      chk("t1_k0100", int'(kernel[0][1][0][0]), 25);
      chk("t1_f000", int'(featuremap1[0][0][0]), 100);
      chk("t1_f11313", int'(featuremap1[1][13][13]), 491);
      chk("t1_kernel", kern_errs(1'b0), 0);
      chk("t1_fmap", fm_errs(0), 0);
      do_consume("t1");

      // Reuse the stored kernel, negative pixel words.
      run_load(1'b1, 1'b0, 1'b1, -1, -1, -1, cyc, n);
      chk("t2_latency", cyc, 393);
      chk("t2_f001", int'(featuremap1[0][0][1]), -1);
      raw = featuremap1[0][0][1];
      chk("t2_f001_raw", int'(raw), 32'hFFFF);
      chk("t2_f11313", int'(featuremap1[1][13][13]), -391);
      chk("t2_kernel_kept", kern_errs(1'b0), 0);
      chk("t2_fmap", fm_errs(1), 0);
      do_consume("t2");

      // Random in_valid gaps rewrite the map back to positive words.
      run_load(1'b0, 1'b1, 1'b0, -1, -1, -1, cyc, n);
      chk("t3_stalled", int'(cyc > 493), 1);
      chk("t3_kernel", kern_errs(1'b0), 0);
      chk("t3_fmap", fm_errs(0), 0);
      do_consume("t3");

      // start during LOAD_F and consume during LOAD_K are ignored.
      run_load(1'b0, 1'b0, 1'b0, 200, 50, -1, cyc, n);
      chk("t4_latency", cyc, 493);
      chk("t4_kernel", kern_errs(1'b0), 0);
      chk("t4_fmap", fm_errs(0), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_ready_start_ignored", operands_valid, 1);
      chk("t4_ready_not_busy", busy, 0);
      start   = 1'b1;
      consume = 1'b1;
      tick();
      start   = 1'b0;
      consume = 1'b0;
      chk("t4_both_valid", operands_valid, 0);
      chk("t4_both_busy", busy, 0);
      tick();
      tick();
      chk("t4_no_queued_start", busy, 0);
      chk("t4_idle_in_ready", bus.in_ready, 0);

      // Asynchronous reset at beat 250.
      run_load(1'b0, 1'b0, 1'b0, -1, -1, 250, cyc, n);
      chk("t5_midload_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_in_ready", bus.in_ready, 0);
      chk("t5_async_valid", operands_valid, 0);
      chk("t5_async_busy", busy, 0);
      chk("t5_async_kernel", kern_errs(1'b1), 0);
      chk("t5_async_fmap", fm_errs(2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("t5_post_busy", busy, 0);
      chk("t5_post_in_ready", bus.in_ready, 0);
      chk("t5_post_valid", operands_valid, 0);
      run_load(1'b0, 1'b0, 1'b0, -1, -1, -1, cyc, n);
      chk("t5_latency", cyc, 493);
      chk("t5_kernel", kern_errs(1'b0), 0);
      chk("t5_fmap", fm_errs(0), 0);
      do_consume("t5");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
